// File: rtl/sphere_stream_pkg.sv
// Purpose: shared types and constants for the sphere point streamer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package sphere_stream_pkg;

    // Run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    // 1.0 in Q16.16
    localparam logic [31:0] ONE = 32'h0001_0000;

    localparam int COORD_W = 32;

    // Captured generator result, x in the most significant word
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } point_t;

    // FIFO entry is {x, y, z, k, last}; only k has a configurable width
    localparam int ENTRY_FIXED_W = 3 * COORD_W + 1;

    function automatic int entry_width(input int k_width);
        return ENTRY_FIXED_W + k_width;
    endfunction

    // True when |v| > 1.0 for a signed Q16.16 value
    function automatic logic exceeds_one(input logic [COORD_W-1:0] v);
        return ($signed(v) > $signed(ONE)) || ($signed(v) < -$signed(ONE));
    endfunction

endpackage

// File: rtl/sphere_stream_fifo.sv
// Purpose: synchronous circular FIFO with registered head entry and valid flag.
// Latency: a push into an empty FIFO is visible on head outputs the cycle after the write edge.
// Backpressure: full is asserted at DEPTH entries; the writer must not push while full.
module sphere_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_n;
    logic [WIDTH-1:0] head_n;
    logic             do_pop;

    assign do_pop = pop & head_valid;
    assign full   = (count == (PTR_W+1)'(DEPTH));

    // Next pointer/count and the entry that becomes the head after this edge
    always_comb begin
        rd_ptr_n = rd_ptr + PTR_W'(do_pop);
        count_n  = count + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop);
        head_n   = head_data;
        if (count_n == '0) begin
            head_n = head_data;
        end else if (count == (PTR_W+1)'(do_pop)) begin
            // FIFO drains to empty this cycle, so the incoming word is the new head
            head_n = push_data;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    // Storage array; contents need no reset because head_valid gates them
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            head_valid <= (count_n != '0);
            head_data  <= head_n;
        end
    end

endmodule

// File: rtl/sphere_point_streamer.sv
// Purpose: issues one sphere generator request per index of a run and streams tagged Q16.16 points; range check under SPHERE_STREAM_RANGE_CHECK_EN.
// Latency: generator done edge sampled at M -> FIFO write at M+1 -> out_valid after M+1; run_done one cycle after the last capture.
// Backpressure: out_ready low fills the FIFO; no new generator request is issued while the FIFO is full.
module sphere_point_streamer
    import sphere_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int K_WIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [K_WIDTH-1:0] cfg_k_first,
    input  logic [31:0]        cfg_count,
    input  logic [1:0]         cfg_base_sel0,
    input  logic [1:0]         cfg_base_sel1,
    input  logic               abort,
    output logic               busy,
    output logic               run_done,
    output logic               gen_start,
    output logic [K_WIDTH-1:0] gen_k,
    output logic [1:0]         gen_base_sel0,
    output logic [1:0]         gen_base_sel1,
    input  logic               gen_ready,
    input  logic               gen_done,
    input  logic [31:0]        gen_x,
    input  logic [31:0]        gen_y,
    input  logic [31:0]        gen_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_x,
    output logic [31:0]        out_y,
    output logic [31:0]        out_z,
    output logic [K_WIDTH-1:0] out_k,
    output logic               out_last,
    output logic               err_range
);

    localparam int ENTRY_W = entry_width(K_WIDTH);

    state_t             state;
    state_t             state_n;
    logic [K_WIDTH-1:0] k_cur;
    logic [31:0]        remaining;
    logic [1:0]         sel0_q;
    logic [1:0]         sel1_q;
    logic               abort_flag;
    logic               done_q;
    logic               done_edge;
    point_t             cap_pt;
    logic               accept;
    logic               push;
    logic               gen_start_n;
    logic               run_done_n;
    logic               fifo_full;
    logic               last_bit;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;

    // A done level held over from an earlier request produces no edge
    assign done_edge     = gen_done & ~done_q;
    assign last_bit      = (remaining == 32'd1);
    assign push_data     = {cap_pt, k_cur, last_bit};
    assign gen_k         = k_cur;
    assign gen_base_sel0 = sel0_q;
    assign gen_base_sel1 = sel1_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle controls
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        push        = 1'b0;
        gen_start_n = 1'b0;
        run_done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                // busy is still high for the cycle after run_done
                if (cfg_start && !busy) begin
                    accept  = 1'b1;
                    state_n = (cfg_count == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_n = ST_FINISH;
                end else if (gen_ready && !fifo_full) begin
                    gen_start_n = 1'b1;
                    state_n     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // An aborted request still runs to completion; its result is dropped
                if (done_edge) begin
                    state_n = (abort_flag || abort) ? ST_FINISH : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                state_n = last_bit ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                run_done_n = 1'b1;
                state_n    = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Run context, generator handshake and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            run_done   <= 1'b0;
            gen_start  <= 1'b0;
            k_cur      <= '0;
            remaining  <= '0;
            sel0_q     <= '0;
            sel1_q     <= '0;
            abort_flag <= 1'b0;
            done_q     <= 1'b0;
            cap_pt     <= '0;
        end else begin
            done_q    <= gen_done;
            gen_start <= gen_start_n;
            run_done  <= run_done_n;
            if (accept) begin
                busy <= 1'b1;
            end else if (run_done) begin
                busy <= 1'b0;
            end
            if (accept) begin
                k_cur     <= cfg_k_first;
                remaining <= cfg_count;
                sel0_q    <= cfg_base_sel0;
                sel1_q    <= cfg_base_sel1;
            end else if (push) begin
                k_cur     <= k_cur + K_WIDTH'(1);
                remaining <= remaining - 32'd1;
            end
            if (accept || state == ST_FINISH) begin
                abort_flag <= 1'b0;
            end else if (state == ST_WAIT_DONE && abort) begin
                abort_flag <= 1'b1;
            end
            if (state == ST_WAIT_DONE && done_edge) begin
                cap_pt <= '{x: gen_x, y: gen_y, z: gen_z};
            end
        end
    end

`ifdef SPHERE_STREAM_RANGE_CHECK_EN
    logic err_q;

    // Sticky out-of-range flag, cleared when a new run is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (push && (exceeds_one(cap_pt.x) || exceeds_one(cap_pt.y) ||
                              exceeds_one(cap_pt.z))) begin
            err_q <= 1'b1;
        end
    end

    assign err_range = err_q;
`else
    assign err_range = 1'b0;
`endif

    sphere_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (out_ready),
        .full       (fifo_full),
        .head_valid (out_valid),
        .head_data  (head_data)
    );

    assign {out_x, out_y, out_z, out_k, out_last} = head_data;

endmodule

// File: tb/tb_sphere_point_streamer.sv
// Purpose: directed plus randomized bench for sphere_point_streamer with a behavioural Halton-sphere generator.
// Latency: generator model answers a configurable number of cycles after each start.
// Backpressure: out_ready held low, held high or randomized per phase.
module tb_sphere_point_streamer;

    localparam int FIFO_DEPTH = 4;
    localparam int K_WIDTH    = 32;
`ifdef SPHERE_STREAM_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] k;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [31:0] cfg_k_first;
    logic [31:0] cfg_count;
    logic [1:0]  cfg_base_sel0;
    logic [1:0]  cfg_base_sel1;
    logic        abort;
    logic        busy;
    logic        run_done;
    logic        gen_start;
    logic [31:0] gen_k;
    logic [1:0]  gen_base_sel0;
    logic [1:0]  gen_base_sel1;
    logic        gen_ready;
    logic        gen_done;
    logic [31:0] gen_x;
    logic [31:0] gen_y;
    logic [31:0] gen_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_z;
    logic [31:0] out_k;
    logic        out_last;
    logic        err_range;

    int    errors = 0;
    int    checks = 0;
    int    starts = 0;
    int    dones  = 0;
    int    rdy_mode = 1;
    int    glat = 5;
    logic  z_over = 1'b0;
    beat_t exp_q[$];
    beat_t rx_log[$];

    sphere_point_streamer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .K_WIDTH    (K_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_k_first   (cfg_k_first),
        .cfg_count     (cfg_count),
        .cfg_base_sel0 (cfg_base_sel0),
        .cfg_base_sel1 (cfg_base_sel1),
        .abort         (abort),
        .busy          (busy),
        .run_done      (run_done),
        .gen_start     (gen_start),
        .gen_k         (gen_k),
        .gen_base_sel0 (gen_base_sel0),
        .gen_base_sel1 (gen_base_sel1),
        .gen_ready     (gen_ready),
        .gen_done      (gen_done),
        .gen_x         (gen_x),
        .gen_y         (gen_y),
        .gen_z         (gen_z),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_z         (out_z),
        .out_k         (out_k),
        .out_last      (out_last),
        .err_range     (err_range)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Van der Corput radical inverse of k in base b
    function automatic real radinv(input logic [31:0] k, input int b);
        real f;
        real r;
        longint unsigned kk;
        longint unsigned bb;
        f  = 1.0;
        r  = 0.0;
        kk = 64'(k);
        bb = 64'(b);
        while (kk != 0) begin
            f  = f / real'(bb);
            r  = r + f * real'(kk % bb);
            kk = kk / bb;
        end
        return r;
    endfunction

    function automatic logic [31:0] to_q(input real v);
        int i;
        i = $rtoi(v * 65536.0);
        return 32'(i);
    endfunction

    // Uniform sphere point from a 2-D Halton pair, bases sel+2
    function automatic beat_t model_point(input logic [31:0] k, input logic [1:0] s0,
                                          input logic [1:0] s1, input logic zo);
        beat_t p;
        real u, v, zz, r, phi;
        u   = radinv(k, int'(s0) + 2);
        v   = radinv(k, int'(s1) + 2);
        zz  = 2.0 * u - 1.0;
        r   = 1.0 - zz * zz;
        if (r < 0.0) r = 0.0;
        r   = $sqrt(r);
        phi = 2.0 * 3.14159265358979 * v;
        p.k    = k;
        p.x    = to_q(r * $cos(phi));
        p.y    = to_q(r * $sin(phi));
        p.z    = zo ? 32'h0001_8000 : to_q(zz);
        p.last = 1'b0;
        return p;
    endfunction

    // Generator model: done level stays high until the next start
    initial begin
        int    cnt;
        beat_t pend;
        cnt = 0;
        gen_ready = 1'b1;
        gen_done  = 1'b0;
        gen_x = '0;
        gen_y = '0;
        gen_z = '0;
        forever begin
            @(negedge clk);
            if (run_done === 1'b1) dones++;
            if (rst) begin
                gen_ready = 1'b1;
                gen_done  = 1'b0;
                cnt       = 0;
            end else if (gen_start === 1'b1) begin
                starts++;
                pend      = model_point(gen_k, gen_base_sel0, gen_base_sel1, z_over);
                gen_ready = 1'b0;
                gen_done  = 1'b0;
                cnt       = glat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    gen_x     = pend.x;
                    gen_y     = pend.y;
                    gen_z     = pend.z;
                    gen_done  = 1'b1;
                    gen_ready = 1'b1;
                end
            end
        end
    end

    // Output consumer and scoreboard
    initial begin
        beat_t got;
        beat_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (!rst && out_valid === 1'b1 && out_ready) begin
                got.k = out_k; got.x = out_x; got.y = out_y; got.z = out_z; got.last = out_last;
                rx_log.push_back(got);
                check("beat_was_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_k", 64'(got.k), 64'(e.k));
                    check("beat_x", 64'(got.x), 64'(e.x));
                    check("beat_y", 64'(got.y), 64'(e.y));
                    check("beat_z", 64'(got.z), 64'(e.z));
                    check("beat_last", 64'(got.last), 64'(e.last));
                end
            end
        end
    end

    task automatic start_run(input logic [31:0] kf, input logic [31:0] cnt,
                             input logic [1:0] s0, input logic [1:0] s1, input int n_exp);
        beat_t b;
        for (int i = 0; i < n_exp; i++) begin
            b      = model_point(kf + 32'(i), s0, s1, z_over);
            b.last = (n_exp == int'(cnt)) && (i == n_exp - 1);
            exp_q.push_back(b);
        end
        @(negedge clk);
        cfg_k_first   = kf;
        cfg_count     = cnt;
        cfg_base_sel0 = s0;
        cfg_base_sel1 = s1;
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start     = 1'b0;
    endtask

    task automatic wait_run_done(input string tag, input int budget);
        int n;
        n = 0;
        while (run_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_run_done_seen"}, 64'(run_done), 64'd1);
        if (run_done === 1'b1) begin
            check({tag, "_busy_with_done"}, 64'(busy), 64'd1);
            @(negedge clk);
            check({tag, "_run_done_one_cycle"}, 64'(run_done), 64'd0);
            check({tag, "_busy_falls"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int          s0, d0, n, dx, cnt_r;
        logic [31:0] kf_r;
        rst = 1'b1; cfg_start = 1'b0; cfg_k_first = '0; cfg_count = '0;
        cfg_base_sel0 = '0; cfg_base_sel1 = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(run_done), 64'd0);
        check("rst_gen_start", 64'(gen_start), 64'd0);
        check("rst_gen_k", 64'(gen_k), 64'd0);
        check("rst_gen_sel0", 64'(gen_base_sel0), 64'd0);
        check("rst_gen_sel1", 64'(gen_base_sel1), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_x", 64'(out_x), 64'd0);
        check("rst_out_k", 64'(out_k), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_err_range", 64'(err_range), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic run: k 1..3, bases 2 and 3
        rx_log.delete(); s0 = starts; d0 = dones; rdy_mode = 1; glat = 5;
        start_run(32'd1, 32'd3, 2'd0, 2'd1, 3);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        check("t1_no_gen_start_yet", 64'(gen_start), 64'd0);
        @(negedge clk);
        check("t1_gen_start_first", 64'(gen_start), 64'd1);
        check("t1_gen_k", 64'(gen_k), 64'd1);
        check("t1_gen_sel0", 64'(gen_base_sel0), 64'd0);
        check("t1_gen_sel1", 64'(gen_base_sel1), 64'd1);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            if (gen_done === 1'b1) break;
            n++;
        end
        check("t1_gen_done_seen", 64'(gen_done), 64'd1);
        @(negedge clk);
        check("t1_out_valid_at_M", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_out_valid_at_M1", 64'(out_valid), 64'd1);
        wait_run_done("t1", 200);
        wait_drain("t1", 50);
        check("t1_gen_starts", 64'(starts - s0), 64'd3);
        check("t1_run_dones", 64'(dones - d0), 64'd1);
        check("t1_beats", 64'(rx_log.size()), 64'd3);
        if (rx_log.size() != 0) begin
            dx = $signed(rx_log[0].x) + 32768;
            check("t1_k1_x_near_minus_half", 64'((dx >= -8) && (dx <= 8)), 64'd1);
        end

        // Backpressure: FIFO fills after four requests
        rx_log.delete(); s0 = starts; rdy_mode = 0;
        start_run(32'd10, 32'd6, 2'd2, 2'd1, 6);
        repeat (80) @(negedge clk);
        check("t2_starts_while_full", 64'(starts - s0), 64'd4);
        check("t2_out_valid_held", 64'(out_valid), 64'd1);
        check("t2_head_k_held", 64'(out_k), 64'd10);
        check("t2_busy_stalled", 64'(busy), 64'd1);
        rdy_mode = 1;
        wait_run_done("t2", 300);
        wait_drain("t2", 50);
        check("t2_gen_starts", 64'(starts - s0), 64'd6);
        check("t2_beats", 64'(rx_log.size()), 64'd6);

        // Zero-count run
        s0 = starts; d0 = dones;
        start_run(32'd5, 32'd0, 2'd0, 2'd0, 0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_run_done_early", 64'(run_done), 64'd0);
        @(negedge clk);
        check("t3_run_done_pulse", 64'(run_done), 64'd1);
        @(negedge clk);
        check("t3_run_done_low", 64'(run_done), 64'd0);
        check("t3_busy_low", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("t3_no_gen_start", 64'(starts - s0), 64'd0);
        check("t3_run_dones", 64'(dones - d0), 64'd1);
        check("t3_out_valid", 64'(out_valid), 64'd0);

        // Index wrap
        rx_log.delete();
        start_run(32'hFFFF_FFFF, 32'd2, 2'd1, 2'd2, 2);
        wait_run_done("t4", 200);
        wait_drain("t4", 50);
        check("t4_beats", 64'(rx_log.size()), 64'd2);
        if (rx_log.size() == 2) begin
            check("t4_k_first", 64'(rx_log[0].k), 64'hFFFF_FFFF);
            check("t4_k_wrapped", 64'(rx_log[1].k), 64'd0);
        end

        // Abort while the second request is outstanding
        rx_log.delete(); s0 = starts; d0 = dones;
        start_run(32'd20, 32'd5, 2'd0, 2'd1, 1);
        n = 0;
        while (starts - s0 < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_request", 64'(starts - s0), 64'd2);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_run_done("t5", 100);
        wait_drain("t5", 50);
        repeat (10) @(negedge clk);
        check("t5_no_more_starts", 64'(starts - s0), 64'd2);
        check("t5_beats", 64'(rx_log.size()), 64'd1);
        check("t5_run_dones", 64'(dones - d0), 64'd1);

        // Range check on an out-of-range z, cleared by the next start
        z_over = 1'b1;
        start_run(32'd7, 32'd1, 2'd0, 2'd1, 1);
        wait_run_done("t6", 100);
        wait_drain("t6", 50);
        check("t6_err_range_set", 64'(err_range), 64'(RANGE_EN));
        z_over = 1'b0;
        start_run(32'd8, 32'd1, 2'd0, 2'd1, 1);
        check("t6_err_range_cleared", 64'(err_range), 64'd0);
        wait_run_done("t6b", 100);
        wait_drain("t6b", 50);

        // Randomized runs with random latency and consumer stalls
        rdy_mode = 2;
        for (int r = 0; r < 6; r++) begin
            glat  = $urandom_range(1, 7);
            kf_r  = $urandom;
            cnt_r = $urandom_range(1, 6);
            s0    = starts;
            start_run(kf_r, 32'(cnt_r), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), cnt_r);
            wait_run_done("rnd", 500);
            wait_drain("rnd", 300);
            check("rnd_gen_starts", 64'(starts - s0), 64'(cnt_r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sphere_point_streamer.md
# sphere_point_streamer

Run-level sequencer that sits directly upstream of the sphere point generator (`sphere_fsm_32bit_simple`). It accepts a run descriptor (first index, point count, base selects) and issues one generator request per index using the generator's start/ready/done handshake. Each returned Q16.16 (x, y, z) triple is captured into an output FIFO, tagged with its index, and presented on a valid/ready stream for downstream consumers.

## Interface
- `FIFO_DEPTH`, 4 — output FIFO entries; power of two, minimum 2.
- `K_WIDTH`, 32 — index width; must match the generator's `k_in`.
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `cfg_start`  in  1  — single-cycle pulse that launches a run; ignored while `busy`=1.
- `cfg_k_first`  in  K_WIDTH  — first index of the run.
- `cfg_count`  in  32  — number of points in the run.
- `cfg_base_sel0`, `cfg_base_sel1`  in  2 each — base selects, passed through to the generator.
- `abort`  in  1  — terminate the current run early.
- `busy`  out  1  — high from the accepted `cfg_start` until the cycle after `run_done`.
- `run_done`  out  1  — one-cycle pulse at the end of a run.
- `gen_start`  out  1  — generator start; single-cycle pulse.
- `gen_k`  out  K_WIDTH  — generator index.
- `gen_base_sel0`, `gen_base_sel1`  out  2 each — generator base selects.
- `gen_ready`, `gen_done`  in  1 each — generator status.
- `gen_x`, `gen_y`, `gen_z`  in  32 each — generator results, Q16.16 signed.
- `out_valid`  out  1 / `out_ready`  in  1 — output stream handshake.
- `out_x`, `out_y`, `out_z`  out  32 each — point coordinates.
- `out_k`  out  K_WIDTH — index of the point on the output.
- `out_last`  out  1 — marks the final point of a run.
- `err_range`  out  1 — sticky range error; see Configuration.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_DONE, CAPTURE, FINISH.
- **IDLE**
  - On `cfg_start`, latch `cfg_k_first`, `cfg_count` and both base selects.
  - `cfg_count`=0 → FINISH. Otherwise → ISSUE.
- **ISSUE**
  - When `gen_ready`=1 and the FIFO is not full, pulse `gen_start` for one cycle with `gen_k` = current index, then → WAIT_DONE.
  - Otherwise stall in ISSUE.
- **WAIT_DONE**
  - Capture on the rising edge of `gen_done` (`gen_done`=1 while its registered copy is 0), then → CAPTURE.
  - A `gen_done` level left high from an earlier request is never captured.
- **CAPTURE**
  - Push {x, y, z, k, last} into the FIFO. `last` = (remaining count = 1).
  - Increment the index modulo 2^K_WIDTH (0xFFFFFFFF wraps to 0) and decrement the remaining count.
  - Remaining count reaches 0 → FINISH. Otherwise → ISSUE.
- **FINISH**
  - Pulse `run_done`, → IDLE.
- **Abort**
  - `abort` in ISSUE → FINISH. No further `gen_start` is issued.
  - `abort` in WAIT_DONE: set an abort flag, still wait for the `gen_done` edge, discard the result (no push), then → FINISH.
  - Points already in the FIFO are kept. If a run is aborted, no entry carries `out_last`.
- **FIFO**
  - Push only from CAPTURE. Space is guaranteed because ISSUE checks for not-full and only one request is ever in flight.
  - Pop when `out_valid` & `out_ready`. A simultaneous push and pop is legal and leaves the count unchanged.
  - Outputs are driven from the head entry and are stable while `out_valid`=1 and `out_ready`=0.
- `gen_base_sel0`/`gen_base_sel1` hold the latched values for the whole run.

## Timing
- **Reset values:** every output is 0 (`busy`, `run_done`, `gen_start`, `gen_k`, both `gen_base_sel` outputs, `out_valid`, `out_x`/`out_y`/`out_z`, `out_k`, `out_last`, `err_range`). FIFO empty, FSM in IDLE.
- **Reset mid-run:** the FIFO is flushed and any in-flight generator result is ignored.
- **Run start:** `cfg_start` at edge N → `busy`=1 after N. Earliest `gen_start` is high after edge N+1.
- **Generator done to output:** `gen_done` edge sampled at edge M → FIFO write at M+1 → `out_valid`=1 after M+1.
- **Run end:** the final CAPTURE at edge P → `run_done` high after P+1 for one cycle → `busy` falls after P+2.
- **Zero-count run:** `run_done` two cycles after `cfg_start`, with no `gen_start`.
- **Back-to-back requests:** at least 3 cycles plus the generator latency between consecutive `gen_start` pulses.

## Configuration
- **`SPHERE_STREAM_RANGE_CHECK_EN` defined**
  - During CAPTURE, check each coordinate for |v| > 0x00010000 (1.0 in Q16.16).
  - Any violation sets `err_range`. It stays set until `rst` or the next accepted `cfg_start`.
  - The point is still pushed unchanged.
- **Undefined:** `err_range` is tied to 0 and no comparator logic is present.

## Structure
- **Shared package `sphere_stream_pkg`:**
  - FSM state encoding.
  - Q16.16 constant ONE = 32'h0001_0000.
  - FIFO entry struct/width constant: 3×32 + K_WIDTH + 1 bits.
- **Sub-module `sphere_stream_fifo`:** synchronous FIFO with circular pointers, count, full/empty and registered head outputs. It is the only sub-module; the FSM lives in the top level.

## Test plan
1. **Basic run:** `cfg_k_first`=1, `cfg_count`=3, bases [2,3] (sel 0,1), behavioural generator model with 5-cycle latency, `out_ready`=1.
   → Three beats with `out_k` 1,2,3; the k=1 beat has `out_x`≈0xFFFF8000 (−0.5); `out_last` only on k=3; one `run_done` pulse; exactly 3 `gen_start` pulses.
2. **Backpressure:** `FIFO_DEPTH`=4, `cfg_count`=6, `out_ready`=0.
   → Exactly 4 `gen_start` pulses, then stall in ISSUE. Raising `out_ready` drains 6 beats in order with no loss or duplication.
3. **Zero count:** `cfg_count`=0.
   → `run_done` 2 cycles after `cfg_start`; no `gen_start`; `out_valid` stays 0.
4. **Index wrap:** `cfg_k_first`=0xFFFFFFFF, `cfg_count`=2.
   → `out_k` is 0xFFFFFFFF, then 0x00000000.
5. **Abort in WAIT_DONE:** assert `abort` during the second request of a 5-point run.
   → Only 1 beat is output; the second result is discarded; `run_done` pulses; `out_last` is never set.
6. **Range check (macro defined):** generator model returns `gen_z`=0x00018000.
   → `err_range`=1 from the capture cycle onward; it clears on the next `cfg_start`.
